// File: rtl/tristate_bus_ctrl_if.sv
// Request/grant bundle between the tri-state bus controller and its drivers/readers.
// Latency: none, wires only.
// Backpressure: none here; the controller gates ownership through gnt.
interface tristate_bus_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int N_DRV = 4
);
    logic [N_DRV-1:0]       req;
    logic [N_DRV*WIDTH-1:0] din;
    logic                   ext_oe;
    logic [N_DRV-1:0]       gnt;
    logic [WIDTH-1:0]       bus_rd;
    logic                   busy;
    logic                   contention;

    modport master (
        input  req, din, ext_oe,
        output gnt, bus_rd, busy, contention
    );

    modport slave (
        output req, din, ext_oe,
        input  gnt, bus_rd, busy, contention
    );
endinterface

// File: rtl/tristate_bus_ctrl.sv
// Round-robin owner of a shared tri-state bus; optional keeper via TRISTATE_BUS_KEEPER_EN.
// Latency: grant one cycle after req is sampled; TURN_CYC dead (all-Z) cycles between owners.
// Backpressure: ext_oe blocks new grants and preempts the owner; MAX_HOLD bounds tenure under contention.
module tristate_bus_ctrl #(
    parameter int WIDTH    = 8,
    parameter int N_DRV    = 4,
    parameter int TURN_CYC = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    tristate_bus_ctrl_if.master bif,
    inout  wire  [WIDTH-1:0]    bus
);
    localparam int IW = $clog2(N_DRV);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam int TW = $clog2(TURN_CYC + 1);

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t           state;
    logic [N_DRV-1:0] gnt_q;
    logic             busy_q;
    logic             cont_q;
    logic [IW-1:0]    rr_ptr;
    logic [HW-1:0]    hold_cnt;
    logic [TW-1:0]    turn_cnt;

    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic [IW-1:0]    next_ptr;
    logic [N_DRV-1:0] win_oh;
    logic             own_req;
    logic             other_req;
    logic             hold_done;
    logic             can_grant;
    logic [WIDTH-1:0] drv_dat;

    // Walk from rr_ptr downwards so the closest requester after the pointer wins last.
    always_comb begin
        logic [IW:0] sum;
        sum     = '0;
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = N_DRV - 1; k >= 0; k--) begin
            sum = {1'b0, rr_ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N_DRV)) sum = sum - (IW+1)'(N_DRV);
            if (bif.req[sum[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = sum[IW-1:0];
            end
        end
    end

    assign win_oh    = {{(N_DRV-1){1'b0}}, 1'b1} << win_idx;
    assign next_ptr  = (win_idx == IW'(N_DRV - 1)) ? '0 : win_idx + 1'b1;
    assign own_req   = |(bif.req & gnt_q);
    assign other_req = |(bif.req & ~gnt_q);
    assign hold_done = (hold_cnt >= HW'(MAX_HOLD - 1));
    assign can_grant = win_vld & ~bif.ext_oe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            cont_q   <= 1'b0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
        end else begin
            cont_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        state    <= DRIVE;
                        gnt_q    <= win_oh;
                        rr_ptr   <= next_ptr;
                        busy_q   <= 1'b1;
                        hold_cnt <= '0;
                        turn_cnt <= '0;
                    end
                end
                DRIVE: begin
                    if (bif.ext_oe || !own_req || (hold_done && other_req)) begin
                        state    <= TURN;
                        gnt_q    <= '0;
                        cont_q   <= bif.ext_oe;
                        hold_cnt <= '0;
                        turn_cnt <= '0;
                    end else if (hold_cnt != HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TW'(TURN_CYC - 1)) begin
                        hold_cnt <= '0;
                        turn_cnt <= '0;
                        if (can_grant) begin
                            state  <= DRIVE;
                            gnt_q  <= win_oh;
                            rr_ptr <= next_ptr;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        drv_dat = '0;
        for (int i = 0; i < N_DRV; i++)
            drv_dat = drv_dat | (bif.din[i*WIDTH +: WIDTH] & {WIDTH{gnt_q[i]}});
    end

    // Enable comes straight from the async-reset grant flops, so reset floats the bus at once.
    assign bus = (|gnt_q) ? drv_dat : {WIDTH{1'bz}};

    assign bif.gnt        = gnt_q;
    assign bif.busy       = busy_q;
    assign bif.contention = cont_q;

`ifdef TRISTATE_BUS_KEEPER_EN
    logic [WIDTH-1:0] keep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            keep_q <= '0;
        else if (state == DRIVE || bif.ext_oe)
            keep_q <= bus;
    end

    assign bif.bus_rd = keep_q;
`else
    assign bif.bus_rd = bus;
`endif
endmodule

// File: tb/tb_tristate_bus_ctrl.sv
// Randomized bench for tristate_bus_ctrl against an owner/tenure/gap reference model.
module tb_tristate_bus_ctrl;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int TC = 1;
    localparam int MH = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    wire [W-1:0] bus;

    tristate_bus_ctrl_if #(.WIDTH(W), .N_DRV(N)) bif();

    tristate_bus_ctrl #(.WIDTH(W), .N_DRV(N), .TURN_CYC(TC), .MAX_HOLD(MH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bif   (bif),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Reference model: who owns the bus, for how long, how much gap is left, who is next in line.
    int   m_owner;
    int   m_tenure;
    int   m_gap;
    int   m_next;
    logic m_cont;
`ifdef TRISTATE_BUS_KEEPER_EN
    logic [W-1:0] m_keep;
    bit           m_keep_ok;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_tenure = 0;
        m_gap    = 0;
        m_next   = 0;
        m_cont   = 1'b0;
`ifdef TRISTATE_BUS_KEEPER_EN
        m_keep    = '0;
        m_keep_ok = 1'b1;
`endif
    endtask

    task automatic release_bus();
        m_owner  = -1;
        m_tenure = 0;
        m_gap    = TC;
    endtask

    task automatic try_grant(input logic [N-1:0] r, input logic e);
        bit found;
        found = 1'b0;
        if (!e) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_next + k) % N;
                if (!found && r[i]) begin
                    found    = 1'b1;
                    m_owner  = i;
                    m_tenure = 0;
                    m_next   = (i + 1) % N;
                end
            end
        end
    endtask

    task automatic model_step();
        logic [N-1:0] r;
        logic         e;
        int           prev;
        r      = bif.req;
        e      = bif.ext_oe;
        prev   = m_owner;
        m_cont = 1'b0;
`ifdef TRISTATE_BUS_KEEPER_EN
        if (prev >= 0) begin
            m_keep    = bif.din[prev*W +: W];
            m_keep_ok = 1'b1;
        end else if (e) begin
            m_keep_ok = 1'b0;
        end
`endif
        if (prev >= 0) begin
            if (m_tenure < MH) m_tenure++;
            if (e) begin
                m_cont = 1'b1;
                release_bus();
            end else if (!r[prev]) begin
                release_bus();
            end else if (m_tenure >= MH && (r & ~(N'(1) << prev)) != '0) begin
                release_bus();
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) try_grant(r, e);
        end else begin
            try_grant(r, e);
        end
    endtask

    task automatic compare_all(input string ph);
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check({ph, "_gnt"},  32'(bif.gnt),        32'(eg));
        check({ph, "_busy"}, 32'(bif.busy),       32'(m_owner >= 0 || m_gap > 0));
        check({ph, "_cont"}, 32'(bif.contention), 32'(m_cont));
        if (m_owner >= 0) begin
            check({ph, "_bus"}, 32'(bus), 32'(bif.din[m_owner*W +: W]));
        end else begin
            // An undriven bus reads Z (4-state) or 0 (2-state); driver data is never zero.
            check({ph, "_bus_z"}, $countones(bus), 0);
        end
`ifdef TRISTATE_BUS_KEEPER_EN
        if (m_keep_ok) check({ph, "_bus_rd"}, 32'(bif.bus_rd), 32'(m_keep));
`else
        if (m_owner >= 0) check({ph, "_bus_rd"}, 32'(bif.bus_rd), 32'(bif.din[m_owner*W +: W]));
        else              check({ph, "_bus_rd_z"}, $countones(bif.bus_rd), 0);
`endif
    endtask

    task automatic cycle(input string ph);
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic rand_din();
        for (int i = 0; i < N; i++) bif.din[i*W +: W] = W'($urandom | 32'h1);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        bif.req    = '0;
        bif.ext_oe = 1'b0;
        model_reset();
        @(negedge clk);
        compare_all("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int           seq[$];
        int           runs[$];
        int           gaps[$];
        int           drun;
        int           zrun;
        logic [N-1:0] prevg;

        n_checks   = 0;
        n_fail     = 0;
        bif.req    = '0;
        bif.ext_oe = 1'b0;
        rand_din();
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("por");
        rst_n = 1'b1;

        // Single requester from idle.
        bif.din[0 +: W] = 8'hA5;
        bif.req = 4'b0001;
        cycle("first");
        check("first_gnt",  32'(bif.gnt),  32'h1);
        check("first_bus",  32'(bus),      32'hA5);
        check("first_busy", 32'(bif.busy), 32'h1);
        repeat (3) cycle("first_hold");

        // All four requesting: round-robin order, fixed tenure and gap lengths.
        apply_reset();
        rand_din();
        bif.req = 4'b1111;
        drun  = 0;
        zrun  = 0;
        prevg = '0;
        for (int c = 0; c < 75; c++) begin
            cycle("rr");
            if (bif.gnt != '0) begin
                if (prevg == '0) begin
                    seq.push_back($clog2(bif.gnt));
                    if (seq.size() > 1) gaps.push_back(zrun);
                    drun = 0;
                end
                drun++;
                zrun = 0;
            end else begin
                if (prevg != '0) runs.push_back(drun);
                zrun++;
            end
            prevg = bif.gnt;
        end
        for (int k = 0; k < 5; k++)
            check("rr_order", (seq.size() > k) ? seq[k] : -1, k % N);
        for (int k = 0; k < 4; k++) begin
            check("rr_tenure", (runs.size() > k) ? runs[k] : -1, MH);
            check("rr_gap",    (gaps.size() > k) ? gaps[k] : -1, TC);
        end

        // External agent takes the bus from driver 2.
        apply_reset();
        rand_din();
        bif.req = 4'b0100;
        repeat (2) cycle("ext_pre");
        bif.ext_oe = 1'b1;
        cycle("ext");
        check("ext_cont",  32'(bif.contention), 32'h1);
        check("ext_gnt",   32'(bif.gnt),        32'h0);
        check("ext_bus_z", $countones(bus),     0);
        repeat (4) cycle("ext_hold");
        check("ext_cont_pulse", 32'(bif.contention), 32'h0);
        bif.ext_oe = 1'b0;
        repeat (4) cycle("ext_post");

        // Driver 1 writes 3C then releases; reader view after release.
        apply_reset();
        rand_din();
        bif.din[1*W +: W] = 8'h3C;
        bif.req = 4'b0010;
        repeat (3) cycle("keep_drv");
        bif.req = 4'b0000;
        repeat (4) cycle("keep_rel");
`ifdef TRISTATE_BUS_KEEPER_EN
        check("keep_bus_rd", 32'(bif.bus_rd), 32'h3C);
`else
        check("keep_bus_rd_z", $countones(bif.bus_rd), 0);
`endif

        // Randomized traffic with occasional external preemption.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(7) == 0) bif.req[i] = ~bif.req[i];
            if (bif.ext_oe) begin
                if ($urandom_range(1) == 0) bif.ext_oe = 1'b0;
            end else if ($urandom_range(39) == 0) begin
                bif.ext_oe = 1'b1;
            end
            if ($urandom_range(3) == 0) rand_din();
            cycle("rand");
        end

        // Asynchronous reset between clock edges while driver 1 owns the bus.
        apply_reset();
        rand_din();
        bif.ext_oe = 1'b0;
        bif.req    = 4'b0010;
        repeat (3) cycle("arst_pre");
        #2 rst_n = 1'b0;
        #1;
        check("arst_gnt",   32'(bif.gnt),  32'h0);
        check("arst_busy",  32'(bif.busy), 32'h0);
        check("arst_bus_z", $countones(bus), 0);
        model_reset();
        @(negedge clk);
        compare_all("arst_hold");
        bif.req = 4'b0100;
        rst_n   = 1'b1;
        cycle("arst_post");
        check("arst_regnt", 32'(bif.gnt), 32'h4);
        repeat (3) cycle("arst_run");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tristate_bus_ctrl.md
TRISTATE_BUS_CTRL -- requirements
Module: tristate_bus_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, shared bus data width in bits (>=1).
REQ-002 Parameter N_DRV, default 4, number of internal drivers (2..16).
REQ-003 Parameter TURN_CYC, default 1, bus turnaround dead cycles between owners (>=1).
REQ-004 Parameter MAX_HOLD, default 16, max consecutive DRIVE cycles while another request is pending (>=1).
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req  input  N_DRV  per-driver bus request, level-sensitive.
REQ-008 din  input  N_DRV*WIDTH  per-driver data; driver i occupies bits [i*WIDTH +: WIDTH].
REQ-009 ext_oe  input  1  external agent is driving the bus.
REQ-010 gnt  output  N_DRV  registered one-hot grant; all-zero when nobody owns the bus.
REQ-011 bus  inout  WIDTH  shared tri-state bus.
REQ-012 bus_rd  output  WIDTH  bus value as seen by readers.
REQ-013 busy  output  1  high in DRIVE and TURN states.
REQ-014 contention  output  1  registered one-cycle pulse on detected drive conflict.

Function
REQ-015 FSM states: IDLE, DRIVE, TURN; gnt is nonzero only in DRIVE.
REQ-016 bus = din slice of the granted driver in DRIVE; bus = all-Z in IDLE and TURN (bufif1 semantics per bit, enable = |gnt).
REQ-017 IDLE -> DRIVE when any req high and ext_oe low; gnt asserts the cycle after req is sampled (1-cycle latency).
REQ-018 Arbitration round-robin: search starts at index (last owner + 1) mod N_DRV; lowest index from there wins.
REQ-019 IDLE with ext_oe high: no grant issued; requests stay pending.
REQ-020 DRIVE -> TURN when owner req drops, or hold counter reaches MAX_HOLD with any other req high, or ext_oe high.
REQ-021 Owner with no competing request holds the bus indefinitely; hold counter saturates at MAX_HOLD.
REQ-022 TURN lasts exactly TURN_CYC cycles, then -> DRIVE (next RR winner, if any req high and ext_oe low) else -> IDLE.
REQ-023 ext_oe high while gnt nonzero: contention pulses high the next cycle; gnt drops the same edge (enter TURN).
REQ-024 Owner dropping req and another req rising in the same cycle: TURN still inserted; no back-to-back grant.
REQ-025 A req withdrawn during TURN is not granted.
REQ-026 Hold counter and turnaround counter reset to 0 on every state entry.

Reset
REQ-027 rst_n low asynchronously forces: state IDLE, gnt 0, busy 0, contention 0, bus all-Z, RR pointer so driver 0 has top priority, counters 0.
REQ-028 Reset asserted mid-DRIVE releases bus to Z immediately, without waiting for clk.
REQ-029 First grant after reset release needs one full clk edge with rst_n high.

Configuration
REQ-030 Macro TRISTATE_BUS_KEEPER_EN selects bus_rd behaviour.
REQ-031 Defined: bus_rd registers bus value each DRIVE cycle (or when ext_oe high) and holds it through TURN/IDLE; reset value 0.
REQ-032 Undefined: bus_rd = bus combinationally (shows Z/X when undriven); no keeper register exists.

Verification
REQ-033 Reset, req=4'b0001, din[0]=8'hA5 -> gnt=0001 next cycle, bus=8'hA5, busy=1.
REQ-034 req=4'b1111 held, MAX_HOLD=16 -> grant order 0,1,2,3,0, each tenure 16 cycles, exactly TURN_CYC Z cycles between.
REQ-035 Driver 2 owning, ext_oe raised -> contention=1 for one cycle, gnt=0 same cycle, bus Z; no grant while ext_oe high.
REQ-036 With TRISTATE_BUS_KEEPER_EN: driver 1 drives 8'h3C then releases -> bus_rd stays 8'h3C through TURN and IDLE; without macro bus_rd=Z.
REQ-037 rst_n pulsed low mid-DRIVE between clk edges -> bus Z and gnt 0 immediately; after release req=0100 -> driver 2 granted, RR restarts from 0.
